// File: rtl/cfg_tilemap_ctrl.sv
// Tile-map write controller: turns PUT / FILL / CLEAR commands into a
// contiguous stream of one-word-per-cycle writes into the config tile RAM.
module cfg_tilemap_ctrl #(
    parameter int unsigned MAP_BASE = 2048,
    parameter int unsigned MAP_COLS = 40,
    parameter int unsigned MAP_ROWS = 23
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [1:0]  cmd_op_in,
    input  logic [4:0]  cmd_row_in,
    input  logic [5:0]  cmd_col_in,
    input  logic [5:0]  cmd_len_in,
    input  logic [7:0]  cmd_tile_in,
    output logic        ram_we_out,
    output logic [11:0] ram_addr_out,
    output logic [7:0]  ram_data_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [1:0]     OP_PUT   = 2'd0;
    localparam logic [1:0]     OP_FILL  = 2'd1;
    localparam logic [1:0]     OP_CLEAR = 2'd2;
    localparam int unsigned    CELLS_I  = MAP_COLS * MAP_ROWS;
    localparam logic [11:0]    BASE_W   = MAP_BASE[11:0];
    localparam logic [4:0]     ROWS_W   = MAP_ROWS[4:0];
    localparam logic [5:0]     COLS_W   = MAP_COLS[5:0];
    localparam logic [9:0]     CELLS_W  = CELLS_I[9:0];
    localparam logic [4:0]     LAST_ROW = ROWS_W - 5'd1;
    localparam logic [5:0]     LAST_COL = COLS_W - 6'd1;

    // row * MAP_COLS as a sum of shifted copies of row (no multiplier).
    function automatic logic [11:0] row_offset(input logic [4:0] row);
        logic [11:0] acc;
        acc = 12'd0;
        for (int i = 0; i < 6; i++) begin
            if (COLS_W[i]) begin
                acc = acc + ({7'd0, row} << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [9:0]  rem_q, rem_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [11:0] start_addr_s;
    logic        bad_cmd_s;

    assign start_addr_s = BASE_W + row_offset(cmd_row_in) + {6'd0, cmd_col_in};
    assign bad_cmd_s    = (cmd_op_in == 2'd3) || (cmd_row_in >= ROWS_W) || (cmd_col_in >= COLS_W);

    // Next-state, write-stream and status computation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        row_d   = row_q;
        col_d   = col_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_in) begin
                    if (cmd_op_in == OP_CLEAR) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        addr_d  = BASE_W;
                        data_d  = cmd_tile_in;
                        row_d   = 5'd0;
                        col_d   = 6'd0;
                        rem_d   = CELLS_W - 10'd1;
                    end else if (bad_cmd_s) begin
                        err_d = 1'b1;
                    end else if ((cmd_op_in == OP_FILL) && (cmd_len_in == 6'd0)) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        addr_d  = start_addr_s;
                        data_d  = cmd_tile_in;
                        row_d   = cmd_row_in;
                        col_d   = cmd_col_in;
                        rem_d   = (cmd_op_in == OP_PUT) ? 10'd0 : ({4'd0, cmd_len_in} - 10'd1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // rem_q counts writes still owed after the one currently on the port.
                if (rem_q == 10'd0) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else if ((row_q == LAST_ROW) && (col_q == LAST_COL)) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + 12'd1;
                    rem_d  = rem_q - 10'd1;
                    if (col_q == LAST_COL) begin
                        col_d = 6'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State, write port and status registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            addr_q  <= 12'd0;
            data_q  <= 8'd0;
            we_q    <= 1'b0;
            row_q   <= 5'd0;
            col_q   <= 6'd0;
            rem_q   <= 10'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready_out = ready_q;
    assign ram_we_out    = we_q;
    assign ram_addr_out  = addr_q;
    assign ram_data_out  = data_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_cfg_tilemap_ctrl.sv
// Directed bench for cfg_tilemap_ctrl: each scenario task drives commands and
// checks write stream, latency and status pulses against hand-computed values.
module tb_cfg_tilemap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_row = 5'd0;
    logic [5:0]  cmd_col = 6'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [7:0]  cmd_tile = 8'd0;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cyc, done_cnt, err_cyc, err_cnt, ready_cyc;
    logic busy1;

    cfg_tilemap_ctrl dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .cmd_valid_in  (cmd_valid),
        .cmd_ready_out (cmd_ready),
        .cmd_op_in     (cmd_op),
        .cmd_row_in    (cmd_row),
        .cmd_col_in    (cmd_col),
        .cmd_len_in    (cmd_len),
        .cmd_tile_in   (cmd_tile),
        .ram_we_out    (ram_we),
        .ram_addr_out  (ram_addr),
        .ram_data_out  (ram_data),
        .busy_out      (busy),
        .done_out      (done),
        .err_out       (err)
    );

    always #5 clk = ~clk;

    // Present a command at a negedge; returns at the negedge of cycle accept+1.
    task automatic issue(input logic [1:0] op, input logic [4:0] row, input logic [5:0] col,
                         input logic [5:0] len, input logic [7:0] tile, input bit keep);
        @(negedge clk);
        cmd_op = op; cmd_row = row; cmd_col = col; cmd_len = len; cmd_tile = tile;
        cmd_valid = 1'b1;
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Record outputs from the current negedge (cycle 1) until ready returns.
    task automatic capture(input int max_cycles);
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc = 0; done_cnt = 0; err_cyc = 0; err_cnt = 0; ready_cyc = 0;
        busy1 = busy;
        for (int c = 1; c <= max_cycles; c++) begin
            if (ram_we === 1'b1) begin
                wr_addr.push_back(int'(ram_addr));
                wr_data.push_back(int'(ram_data));
                wr_cyc.push_back(c);
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = c; end
            if (err === 1'b1) begin err_cnt++; err_cyc = c; end
            if (cmd_ready === 1'b1) begin ready_cyc = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", ram_we); end
        checks++; if (ram_addr !== 12'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", ram_addr); end
        checks++; if (ram_data !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", ram_data); end
        checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {busy, done, err}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_put();
        issue(2'd0, 5'd2, 6'd5, 6'd0, 8'h41, 1'b0);
        capture(10);
        checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL put_count got=%0d exp=1", wr_addr.size()); end
        if (wr_addr.size() > 0) begin
            checks++; if (wr_addr[0] !== 2133) begin failures++; $display("FAIL put_addr got=%0d exp=2133", wr_addr[0]); end
            checks++; if (wr_data[0] !== 32'h41) begin failures++; $display("FAIL put_data got=%0h exp=41", wr_data[0]); end
            checks++; if (wr_cyc[0] !== 1) begin failures++; $display("FAIL put_wcyc got=%0d exp=1", wr_cyc[0]); end
        end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL put_busy got=%b exp=1", busy1); end
        checks++; if (done_cyc !== 2 || done_cnt !== 1) begin failures++; $display("FAIL put_done cyc=%0d cnt=%0d exp cyc=2 cnt=1", done_cyc, done_cnt); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL put_err got=%0d exp=0", err_cnt); end
        checks++; if (ready_cyc !== 3) begin failures++; $display("FAIL put_ready got=%0d exp=3", ready_cyc); end
    endtask

    task automatic test_fill_wrap();
        int bad;
        issue(2'd1, 5'd0, 6'd38, 6'd4, 8'h07, 1'b0);
        capture(20);
        bad = 0;
        foreach (wr_addr[i]) if (wr_addr[i] != 2086 + i || wr_data[i] != 7 || wr_cyc[i] != i + 1) bad++;
        checks++; if (wr_addr.size() !== 4) begin failures++; $display("FAIL fill_count got=%0d exp=4", wr_addr.size()); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL fill_stream bad=%0d exp=0", bad); end
        checks++; if (done_cyc !== 5 || done_cnt !== 1) begin failures++; $display("FAIL fill_done cyc=%0d cnt=%0d exp cyc=5 cnt=1", done_cyc, done_cnt); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL fill_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_fill_trunc();
        int bad;
        issue(2'd1, 5'd22, 6'd37, 6'd5, 8'h33, 1'b0);
        capture(20);
        bad = 0;
        foreach (wr_addr[i]) if (wr_addr[i] != 2965 + i || wr_data[i] != 32'h33) bad++;
        checks++; if (wr_addr.size() !== 3) begin failures++; $display("FAIL trunc_count got=%0d exp=3", wr_addr.size()); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL trunc_stream bad=%0d exp=0", bad); end
        checks++; if (done_cyc !== 4 || err_cyc !== 4 || err_cnt !== 1) begin failures++; $display("FAIL trunc_pulses done=%0d err=%0d errcnt=%0d exp 4 4 1", done_cyc, err_cyc, err_cnt); end
    endtask

    task automatic test_fill_zero();
        issue(2'd1, 5'd3, 6'd3, 6'd0, 8'h09, 1'b0);
        capture(10);
        checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL zero_count got=%0d exp=0", wr_addr.size()); end
        checks++; if (done_cyc !== 1 || ready_cyc !== 2) begin failures++; $display("FAIL zero_timing done=%0d ready=%0d exp 1 2", done_cyc, ready_cyc); end
    endtask

    task automatic test_reject();
        issue(2'd0, 5'd23, 6'd0, 6'd0, 8'h11, 1'b0);
        capture(10);
        checks++; if (wr_addr.size() !== 0 || done_cnt !== 0) begin failures++; $display("FAIL rej_row writes=%0d done=%0d exp 0 0", wr_addr.size(), done_cnt); end
        checks++; if (err_cyc !== 1 || err_cnt !== 1 || ready_cyc !== 1) begin failures++; $display("FAIL rej_row_pulse err=%0d cnt=%0d ready=%0d exp 1 1 1", err_cyc, err_cnt, ready_cyc); end
        issue(2'd3, 5'd1, 6'd1, 6'd1, 8'h11, 1'b0);
        capture(10);
        checks++; if (wr_addr.size() !== 0 || done_cnt !== 0) begin failures++; $display("FAIL rej_op writes=%0d done=%0d exp 0 0", wr_addr.size(), done_cnt); end
        checks++; if (err_cyc !== 1 || err_cnt !== 1 || ready_cyc !== 1) begin failures++; $display("FAIL rej_op_pulse err=%0d cnt=%0d ready=%0d exp 1 1 1", err_cyc, err_cnt, ready_cyc); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rej_err_width got=%b exp=0", err); end
    endtask

    task automatic test_clear_held();
        int bad;
        issue(2'd2, 5'd9, 6'd9, 6'd9, 8'h00, 1'b1);
        cmd_op = 2'd0; cmd_row = 5'd1; cmd_col = 6'd1; cmd_tile = 8'h55;
        capture(1000);
        bad = 0;
        foreach (wr_addr[i]) if (wr_addr[i] != 2048 + i || wr_data[i] != 0 || wr_cyc[i] != i + 1) bad++;
        checks++; if (wr_addr.size() !== 920) begin failures++; $display("FAIL clear_count got=%0d exp=920", wr_addr.size()); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL clear_stream bad=%0d exp=0", bad); end
        checks++; if (done_cyc !== 921 || done_cnt !== 1 || err_cnt !== 0) begin failures++; $display("FAIL clear_done cyc=%0d cnt=%0d err=%0d exp 921 1 0", done_cyc, done_cnt, err_cnt); end
        checks++; if (ready_cyc !== 922) begin failures++; $display("FAIL clear_ready got=%0d exp=922", ready_cyc); end
        @(negedge clk);
        cmd_valid = 1'b0;
        capture(10);
        checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL held_count got=%0d exp=1", wr_addr.size()); end
        if (wr_addr.size() > 0) begin
            checks++; if (wr_addr[0] !== 2089 || wr_data[0] !== 32'h55 || wr_cyc[0] !== 1) begin failures++; $display("FAIL held_write addr=%0d data=%0h cyc=%0d exp 2089 55 1", wr_addr[0], wr_data[0], wr_cyc[0]); end
        end
        checks++; if (done_cyc !== 2) begin failures++; $display("FAIL held_done got=%0d exp=2", done_cyc); end
    endtask

    task automatic test_back_to_back();
        int bad;
        issue(2'd0, 5'd0, 6'd0, 6'd0, 8'hA5, 1'b1);
        cmd_op = 2'd1; cmd_row = 5'd1; cmd_col = 6'd0; cmd_len = 6'd2; cmd_tile = 8'h22;
        capture(10);
        checks++; if (wr_addr.size() !== 1 || ready_cyc !== 3) begin failures++; $display("FAIL b2b_first writes=%0d ready=%0d exp 1 3", wr_addr.size(), ready_cyc); end
        @(negedge clk);
        cmd_valid = 1'b0;
        capture(10);
        bad = 0;
        foreach (wr_addr[i]) if (wr_addr[i] != 2088 + i || wr_data[i] != 32'h22 || wr_cyc[i] != i + 1) bad++;
        checks++; if (wr_addr.size() !== 2 || bad !== 0) begin failures++; $display("FAIL b2b_second writes=%0d bad=%0d exp 2 0", wr_addr.size(), bad); end
        checks++; if (done_cyc !== 3) begin failures++; $display("FAIL b2b_done got=%0d exp=3", done_cyc); end
    endtask

    task automatic test_reset_mid_clear();
        int dn;
        issue(2'd2, 5'd0, 6'd0, 6'd0, 8'h11, 1'b0);
        repeat (99) @(negedge clk);
        checks++; if (ram_we !== 1'b1 || ram_addr !== 12'd2147) begin failures++; $display("FAIL mid_pre we=%b addr=%0d exp 1 2147", ram_we, ram_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_async we=%b busy=%b done=%b exp 000", ram_we, busy, done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", cmd_ready); end
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1 || ram_we === 1'b1) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL mid_resume got=%0d exp=0", dn); end
        issue(2'd0, 5'd2, 6'd5, 6'd0, 8'h41, 1'b0);
        capture(10);
        checks++; if (wr_addr.size() !== 1 || done_cyc !== 2) begin failures++; $display("FAIL mid_put writes=%0d done=%0d exp 1 2", wr_addr.size(), done_cyc); end
        if (wr_addr.size() > 0) begin
            checks++; if (wr_addr[0] !== 2133 || wr_data[0] !== 32'h41) begin failures++; $display("FAIL mid_put_write addr=%0d data=%0h exp 2133 41", wr_addr[0], wr_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_put();
        test_fill_wrap();
        test_fill_trunc();
        test_fill_zero();
        test_reject();
        test_clear_held();
        test_back_to_back();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_tilemap_ctrl.md
CFG_TILEMAP_CTRL -- requirements
Module: cfg_tilemap_ctrl

Interface
REQ-001 Parameter MAP_BASE, default 2048: word address of tile-map cell (row 0, col 0) in the config tile RAM.
REQ-002 Parameter MAP_COLS, default 40: cells per map row.
REQ-003 Parameter MAP_ROWS, default 23: map rows; map size is MAP_COLS*MAP_ROWS = 920 cells.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid_in  input  1  command present.
REQ-007 cmd_ready_out  output  1  controller can accept a command.
REQ-008 cmd_op_in  input  2  0=PUT one cell, 1=FILL run, 2=CLEAR whole map, 3=reserved.
REQ-009 cmd_row_in  input  5  start row.
REQ-010 cmd_col_in  input  6  start column.
REQ-011 cmd_len_in  input  6  FILL run length in cells, 0..63.
REQ-012 cmd_tile_in  input  8  tile index to write.
REQ-013 ram_we_out  output  1  write strobe to the tile RAM write port, one word per cycle.
REQ-014 ram_addr_out  output  12  write address.
REQ-015 ram_data_out  output  8  write data.
REQ-016 busy_out  output  1  high while a command is executing.
REQ-017 done_out  output  1  one-cycle pulse at completion of an accepted command.
REQ-018 err_out  output  1  one-cycle pulse on rejected or truncated command.

Function
REQ-019 FSM states: IDLE, WRITE, FINISH; cmd_ready_out=1 only in IDLE; busy_out=1 in WRITE and FINISH.
REQ-020 Handshake: accept when cmd_valid_in&&cmd_ready_out at a rising edge; all cmd_* fields are latched at that edge; a held cmd_valid_in during busy is ignored until IDLE.
REQ-021 Validation at accept: op 3, row>=MAP_ROWS or col>=MAP_COLS (PUT/FILL only) -> no writes, err_out pulse next cycle, stay IDLE, no done_out.
REQ-022 Start address = MAP_BASE + row*MAP_COLS + col, computed from shifts/adds (row*40 = (row<<5)+(row<<3)) at 12-bit width.
REQ-023 Accepted PUT/FILL/CLEAR: enter WRITE; first ram_we_out=1 in the cycle after accept; one write per cycle, no gaps.
REQ-024 PUT writes exactly 1 cell; FILL writes cmd_len_in cells; CLEAR writes all 920 cells from MAP_BASE with cmd_tile_in, ignoring row/col/len.
REQ-025 Address increments by 1 per write; column counter wraps MAP_COLS-1 -> 0 with row +1 (row-major map, so address stays contiguous).
REQ-026 FILL reaching cell (MAP_ROWS-1, MAP_COLS-1) stops after writing it; if cells remained, err_out pulses with done_out.
REQ-027 FILL with len 0: no writes, go directly to FINISH.
REQ-028 After the last write the FSM enters FINISH for one cycle: ram_we_out=0, done_out=1, then IDLE (ready) next cycle.
REQ-029 ram_addr_out/ram_data_out are registered; when ram_we_out=0 they hold last value (don't-care to consumer).
REQ-030 Latency: PUT accept->done_out = 2 cycles; FILL len N = N+1 cycles; CLEAR = 921 cycles.
REQ-031 Back-to-back: a command presented in the IDLE cycle following FINISH is accepted; minimum command spacing = write count + 2 cycles.

Reset
REQ-032 On rst_in assertion, immediately (asynchronously): state=IDLE, ram_we_out=0, ram_addr_out=0, ram_data_out=0, busy_out=0, done_out=0, err_out=0, counters=0.
REQ-033 cmd_ready_out=1 in the first cycle after rst_in deasserts; an interrupted command is abandoned, no done_out, no resumption.

Verification
REQ-034 PUT row=2 col=5 tile=0x41 -> one write addr 2133 data 0x41 in cycle accept+1; done_out at accept+2; ready at accept+3.
REQ-035 FILL row=0 col=38 len=4 tile=0x07 -> writes addr 2086,2087,2088,2089 on consecutive cycles (col wrap to row 1); done_out, no err.
REQ-036 FILL row=22 col=37 len=5 -> writes 2965,2966,2967 only; done_out and err_out together in the following cycle.
REQ-037 PUT row=23 col=0 and op=3 -> no ram_we_out, err_out one-cycle pulse, cmd_ready_out stays 1, no done_out.
REQ-038 CLEAR tile=0x00 -> exactly 920 writes, addresses 2048..2967 contiguous, done_out at accept+921; cmd_valid_in held high meanwhile accepted only after FINISH.
REQ-039 rst_in asserted mid-CLEAR (after ~100 writes) -> ram_we_out drops without waiting for a clock edge, no done_out, ready=1 after release, next PUT behaves per REQ-034.
